// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM controller slice.
//   - sram_state_e : FSM state encodings (3 bits)
//   - word_t       : 32-bit data word carried between mm and the SRAM
//   - Default timing/geometry constants used by the controller
package sram_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        SRAM_STATE_IDLE    = 3'd0,
        SRAM_STATE_READ    = 3'd1,
        SRAM_STATE_WRITE   = 3'd2,
        SRAM_STATE_RECOVER = 3'd3,
        SRAM_STATE_DONE    = 3'd4
    } sram_state_e;

    localparam int SRAM_DEF_ADDR_WIDTH = 20;
    localparam int SRAM_DEF_READ_WAIT  = 2;
    localparam int SRAM_DEF_WRITE_WAIT = 2;
    localparam int SRAM_CNT_WIDTH      = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response bus between the mm stage and sram_ctrl.
//   mem_access_addr    : word-aligned address (bits[1:0] ignored)
//   mem_access_read    : read strobe
//   mem_access_write   : write strobe
//   mem_access_byte_en : byte lanes for writes
//   mem_access_data_o  : write data from mm
//   mem_access_data_i  : read data back to mm
//   stall              : pipeline hold while an access is in flight
// Modports: master = mm side, slave = controller side.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    word_t       mem_access_addr;
    logic        mem_access_read;
    logic        mem_access_write;
    logic [3:0]  mem_access_byte_en;
    word_t       mem_access_data_o;
    word_t       mem_access_data_i;
    logic        stall;

    modport master (
        output mem_access_addr, mem_access_read, mem_access_write,
               mem_access_byte_en, mem_access_data_o,
        input  mem_access_data_i, stall
    );

    modport slave (
        input  mem_access_addr, mem_access_read, mem_access_write,
               mem_access_byte_en, mem_access_data_o,
        output mem_access_data_i, stall
    );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns mm's single-cycle word request into a timed access on an
// external asynchronous 32-bit SRAM, stalling the pipeline meanwhile.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   mem            : sram_ctrl_if.slave request/response bus from mm
//   sram_addr      : SRAM word address (registered)
//   sram_data_out  : write data for the SRAM bus (registered)
//   sram_data_oe   : tristate enable for sram_data_out (registered)
//   sram_data_in   : data sampled from the SRAM bus
//   sram_ce_n/oe_n/we_n/be_n : active-low SRAM strobes (registered)
// Read  : READ_WAIT+1 stall cycles, data valid on mem_access_data_i in DONE.
// Write : WRITE_WAIT+2 stall cycles, with one RECOVER cycle of data hold
//         after we_n rises.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_DEF_ADDR_WIDTH,
    parameter int READ_WAIT  = SRAM_DEF_READ_WAIT,
    parameter int WRITE_WAIT = SRAM_DEF_WRITE_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_ctrl_if.slave            mem,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_data_out,
    output logic                  sram_data_oe,
    input  logic [31:0]           sram_data_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam logic [SRAM_CNT_WIDTH-1:0] RD_CNT_INIT = SRAM_CNT_WIDTH'(READ_WAIT - 1);
    localparam logic [SRAM_CNT_WIDTH-1:0] WR_CNT_INIT = SRAM_CNT_WIDTH'(WRITE_WAIT - 1);

    sram_state_e               state_q, state_d;
    logic [SRAM_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    word_t                     wdata_q, wdata_d;
    word_t                     rdata_q, rdata_d;
    logic                      data_oe_q, data_oe_d;
    logic                      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic [3:0]                be_n_q, be_n_d;
    logic                      cnt_zero;

    // Byte-offset bits and address bits beyond the SRAM are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_access_addr[31:ADDR_WIDTH+2],
                                mem.mem_access_addr[1:0]};

    assign cnt_zero = (cnt_q == '0);

    // State register plus the registered SRAM-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SRAM_STATE_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            data_oe_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= 4'hf;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            data_oe_q <= data_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
        end
    end

    // Next-state logic. Read wins when both strobes are high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SRAM_STATE_IDLE: begin
                if (mem.mem_access_read)       state_d = SRAM_STATE_READ;
                else if (mem.mem_access_write) state_d = SRAM_STATE_WRITE;
            end
            SRAM_STATE_READ:    if (cnt_zero) state_d = SRAM_STATE_DONE;
            SRAM_STATE_WRITE:   if (cnt_zero) state_d = SRAM_STATE_RECOVER;
            SRAM_STATE_RECOVER: state_d = SRAM_STATE_DONE;
            SRAM_STATE_DONE:    state_d = SRAM_STATE_IDLE;
            default:            state_d = SRAM_STATE_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the
    // combinational stall. Everything holds unless a state changes it.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        data_oe_d = data_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        be_n_d    = be_n_q;
        mem.stall = 1'b1;
        case (state_q)
            SRAM_STATE_IDLE: begin
                mem.stall = mem.mem_access_read | mem.mem_access_write;
                if (mem.mem_access_read) begin
                    addr_d = mem.mem_access_addr[ADDR_WIDTH+1:2];
                    ce_n_d = 1'b0;
                    oe_n_d = 1'b0;
                    be_n_d = 4'h0;
                    cnt_d  = RD_CNT_INIT;
                end else if (mem.mem_access_write) begin
                    addr_d    = mem.mem_access_addr[ADDR_WIDTH+1:2];
                    wdata_d   = mem.mem_access_data_o;
                    be_n_d    = ~mem.mem_access_byte_en;
                    ce_n_d    = 1'b0;
                    data_oe_d = 1'b1;
                    we_n_d    = 1'b0;
                    cnt_d     = WR_CNT_INIT;
                end
            end
            SRAM_STATE_READ: begin
                if (cnt_zero) begin
                    rdata_d = sram_data_in;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SRAM_STATE_WRITE: begin
                // Address, data and byte enables stay put across the we_n edge.
                if (cnt_zero) we_n_d = 1'b1;
                else          cnt_d  = cnt_q - 1'b1;
            end
            SRAM_STATE_RECOVER: begin
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                be_n_d    = 4'hf;
            end
            SRAM_STATE_DONE: begin
                // Pipeline advances on this edge; no new request is taken here.
                mem.stall = 1'b0;
            end
            default: mem.stall = 1'b0;
        endcase
    end

    assign sram_addr             = addr_q;
    assign sram_data_out         = wdata_q;
    assign sram_data_oe          = data_oe_q;
    assign sram_ce_n             = ce_n_q;
    assign sram_oe_n             = oe_n_q;
    assign sram_we_n             = we_n_q;
    assign sram_be_n             = be_n_q;
    assign mem.mem_access_data_i = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl. Each access pushes its
// expected response; a monitor watches stall and, on every completion
// (stall falling), pops the expectation and compares read data, stall
// length, strobe pulse widths, latched address, byte enables and write data.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] sram_addr;
    logic [31:0] sram_data_out;
    logic        sram_data_oe;
    logic [31:0] sram_data_in;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    always #5 clk = ~clk;

    sram_ctrl_if bus ();

    sram_ctrl #(
        .ADDR_WIDTH (20),
        .READ_WAIT  (2),
        .WRITE_WAIT (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (bus),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_data_oe  (sram_data_oe),
        .sram_data_in  (sram_data_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_be_n     (sram_be_n)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          stall_cyc;
        int          oe_cyc;
        int          we_cyc;
        int          doe_cyc;
        logic [19:0] addr;
        logic [3:0]  be_n;
        bit          chk_wdata;
        logic [31:0] wdata;
        int          gap;       // -1: idle gap before the access not checked
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [31:0] rdata_req);
        chk({tag, ".ce_n"},    32'(sram_ce_n),    32'd1);
        chk({tag, ".oe_n"},    32'(sram_oe_n),    32'd1);
        chk({tag, ".we_n"},    32'(sram_we_n),    32'd1);
        chk({tag, ".be_n"},    32'(sram_be_n),    32'hf);
        chk({tag, ".data_oe"}, 32'(sram_data_oe), 32'd0);
        chk({tag, ".stall"},   32'(bus.stall),    32'd0);
        chk({tag, ".rdata"},   bus.mem_access_data_i, rdata_req);
    endtask

    // Monitor: counts strobe activity per access, compares on completion.
    initial begin
        bit          prev_stall = 0;
        bit          cap = 0;
        int          zero_run = 100;
        int          gap_last = -1;
        int          st_c = 0, oe_c = 0, we_c = 0, doe_c = 0;
        logic [19:0] cap_addr = '0;
        logic [3:0]  cap_be = '0;
        logic [31:0] cap_wd = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0; cap = 0; zero_run = 100;
                st_c = 0; oe_c = 0; we_c = 0; doe_c = 0;
                continue;
            end
            if (!sram_oe_n)   oe_c++;
            if (!sram_we_n) begin we_c++; cap_wd = sram_data_out; end
            if (sram_data_oe) doe_c++;
            if (!sram_ce_n && !cap) begin
                cap = 1; cap_addr = sram_addr; cap_be = sram_be_n;
            end
            if (bus.stall) begin
                if (!prev_stall) gap_last = zero_run;
                zero_run = 0;
                st_c++;
            end else begin
                zero_run++;
                if (prev_stall) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_completion actual=1 required=0");
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, ".rdata"},  bus.mem_access_data_i, e.rdata);
                        chk({e.name, ".stall"},  32'(st_c),  32'(e.stall_cyc));
                        chk({e.name, ".oe_cyc"}, 32'(oe_c),  32'(e.oe_cyc));
                        chk({e.name, ".we_cyc"}, 32'(we_c),  32'(e.we_cyc));
                        chk({e.name, ".doe_cyc"},32'(doe_c), 32'(e.doe_cyc));
                        chk({e.name, ".addr"},   32'(cap_addr), 32'(e.addr));
                        chk({e.name, ".be_n"},   32'(cap_be),   32'(e.be_n));
                        if (e.chk_wdata) chk({e.name, ".wdata"}, cap_wd, e.wdata);
                        if (e.gap >= 0)  chk({e.name, ".gap"}, 32'(gap_last), 32'(e.gap));
                    end
                    st_c = 0; oe_c = 0; we_c = 0; doe_c = 0; cap = 0;
                end
            end
            prev_stall = bus.stall;
        end
    end

    task automatic drive_idle();
        bus.mem_access_read    = 1'b0;
        bus.mem_access_write   = 1'b0;
        bus.mem_access_addr    = '0;
        bus.mem_access_byte_en = '0;
        bus.mem_access_data_o  = '0;
    endtask

    task automatic drive_req(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             input logic [31:0] din);
        bus.mem_access_read    = rd;
        bus.mem_access_write   = wr;
        bus.mem_access_addr    = addr;
        bus.mem_access_byte_en = be;
        bus.mem_access_data_o  = wd;
        sram_data_in           = din;
    endtask

    // Issues one access (called just after a rising edge), waits for the
    // completion cycle and drops the request on the following edge.
    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] din,
                          input logic [31:0] rdata_exp, input int stall_exp,
                          input int oe_exp, input int we_exp, input int doe_exp,
                          input logic [19:0] addr_exp, input logic [3:0] be_n_exp,
                          input int gap_exp);
        exp_t e;
        bit   seen = 0;
        bit   done = 0;
        e.name = name; e.rdata = rdata_exp; e.stall_cyc = stall_exp;
        e.oe_cyc = oe_exp; e.we_cyc = we_exp; e.doe_cyc = doe_exp;
        e.addr = addr_exp; e.be_n = be_n_exp; e.chk_wdata = wr && !rd;
        e.wdata = wd; e.gap = gap_exp;
        sb.push_back(e);
        drive_req(rd, wr, addr, be, wd, din);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stall) seen = 1;
            else if (seen) begin done = 1; break; end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s.timeout actual=no_completion required=completion", name);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        sram_data_in = '0;

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle_outputs("reset_init", 32'h0);
        chk("reset_init.addr",   32'(sram_addr), 32'h0);
        chk("reset_init.wdata",  sram_data_out,  32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read and single write.
        access("read1", 1, 0, 32'h0000_1234, 4'h0, 32'h0, 32'hDEADBEEF,
               32'hDEADBEEF, 3, 2, 0, 0, 20'h0048D, 4'h0, -1);
        @(posedge clk); #1;
        access("write1", 0, 1, 32'h0000_0010, 4'b0100, 32'hABABABAB, 32'h1111_1111,
               32'hDEADBEEF, 4, 0, 2, 3, 20'h00004, 4'b1011, -1);
        @(posedge clk); #1;

        // Back-to-back read then write; upper address bits dropped.
        access("b2b_read", 1, 0, 32'hFFF0_0008, 4'h0, 32'h0, 32'h1234_5678,
               32'h1234_5678, 3, 2, 0, 0, 20'hC0002, 4'h0, -1);
        access("b2b_write", 0, 1, 32'h0000_0020, 4'hf, 32'h55AA_55AA, 32'h0,
               32'h1234_5678, 4, 0, 2, 3, 20'h00008, 4'h0, 1);
        @(posedge clk); #1;

        // Both strobes high: read wins, we_n never pulses.
        access("both_rd_wr", 1, 1, 32'h0000_0100, 4'hf, 32'hFFFF_FFFF, 32'hCAFE_F00D,
               32'hCAFE_F00D, 3, 2, 0, 0, 20'h00040, 4'h0, -1);
        @(posedge clk); #1;

        // Reset held for two edges in the middle of a read.
        drive_req(1, 0, 32'h0000_0200, 4'h0, 32'h0, 32'h7777_7777);
        @(negedge clk);
        @(negedge clk);
        chk("rst_read.in_read_oe_n", 32'(sram_oe_n), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_read", 32'h0);
        @(posedge clk); #1;

        // Reset during WRITE abandons the write.
        drive_req(0, 1, 32'h0000_0300, 4'b0011, 32'h0000_0099, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_write.in_write_we_n", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_write", 32'h0);
        @(posedge clk); #1;

        // Normal read after the abandoned write.
        access("read_after_rst", 1, 0, 32'h0000_0044, 4'h0, 32'h0, 32'h0BAD_F00D,
               32'h0BAD_F00D, 3, 2, 0, 0, 20'h00011, 4'h0, -1);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side controller directly downstream of the mm stage.
- Converts mm's single-cycle word-aligned request (address, read/write strobes, byte enables, write data) into multi-cycle timed accesses on an external asynchronous 32-bit SRAM.
- Returns read data on mem_access_data_i toward mm.
- Asserts a stall to the pipeline while an access is in flight.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; sram_addr = mem_access_addr[ADDR_WIDTH+1:2].
- READ_WAIT, 2, cycles oe_n held low before data is sampled; legal range 1..15.
- WRITE_WAIT, 2, cycles we_n held low; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mem_access_addr  in  32  word-aligned address from mm (bits[1:0] ignored).
- mem_access_read  in  1  read request from mm.
- mem_access_write  in  1  write request from mm.
- mem_access_byte_en  in  4  byte lanes for writes.
- mem_access_data_o  in  32  write data from mm (already lane-replicated).
- mem_access_data_i  out  32  read data to mm.
- stall  out  1  pipeline hold request.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_data_out  out  32  data driven onto SRAM bus.
- sram_data_oe  out  1  tristate enable for sram_data_out (top level builds the inout).
- sram_data_in  in  32  data sampled from SRAM bus.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  4  byte enables, active low.

Behaviour:
- Single clock, reset synchronous active-low: sampled only on rising clk edge with rst_n=0.
- Reset values:
  - state=IDLE, wait counter 0.
  - sram_ce_n/oe_n/we_n=1, sram_be_n=4'hf, sram_data_oe=0.
  - sram_addr=0, sram_data_out=0, mem_access_data_i=0.
- All sram_* outputs are registered. stall is combinational.
- States:
  - IDLE:
    - req = read|write. stall = req.
    - If read: latch addr, ce_n=0, oe_n=0, be_n=0000, cnt=READ_WAIT-1, go READ.
    - Else if write: latch addr/data/be_n=~byte_en, ce_n=0, data_oe=1, we_n=0, cnt=WRITE_WAIT-1, go WRITE.
    - Read has priority if both strobes are high.
  - READ: stall=1. If cnt==0: capture sram_data_in into mem_access_data_i, ce_n=1, oe_n=1, go DONE. Else cnt-1.
  - WRITE: stall=1. If cnt==0: we_n=1 (data/be/addr held), go RECOVER. Else cnt-1.
  - RECOVER: stall=1. ce_n=1, data_oe=0, be_n=4'hf, go DONE. Gives one cycle of data hold after the we_n rising edge.
  - DONE: stall=0 so the pipeline advances this edge. Go IDLE unconditionally; a new request is not accepted in DONE.
- Latency:
  - Read: READ_WAIT+1 stall cycles; data valid in DONE.
  - Write: WRITE_WAIT+2 stall cycles.
  - Back-to-back requests: one DONE cycle between accesses.
- mem_access_data_i holds the last read value until the next read capture; writes do not alter it.
- mm holds request inputs stable while stall=1. The controller relies only on latched copies after IDLE.
- Reset mid-access (any state): next edge returns to IDLE with reset output values; the partial write is abandoned.
- The wait counter is 4 bits wide.
- No wrap handling is needed: address bits above ADDR_WIDTH+1 are dropped.

Decomposition:
- Shared defs include gets the state encodings:
  - SRAM_STATE_IDLE=3'd0, READ=3'd1, WRITE=3'd2, RECOVER=3'd3, DONE=3'd4.
- No sub-module: FSM and output registers live in one module. The tristate buffer is instantiated at top level.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-READ -> all strobes high, be_n=4'hf, data_oe=0, stall=0, mem_access_data_i=0.
- Read, READ_WAIT=2, addr=32'h0000_1234, sram_data_in=32'hDEADBEEF:
  - sram_addr=20'h48D, stall high for 3 cycles.
  - oe_n low for 2 cycles.
  - DONE cycle shows mem_access_data_i=32'hDEADBEEF, stall=0.
- Write, byte_en=4'b0100, data=32'hABABABAB, WRITE_WAIT=2:
  - be_n=4'b1011, we_n low exactly 2 cycles.
  - data_oe stays high one cycle after we_n rises.
  - stall high 4 cycles.
- Back-to-back read then write: exactly one stall=0 DONE cycle between; the write's IDLE accept immediately follows.
- Simultaneous read=1, write=1 -> read access performed; we_n never asserts.
- Reset asserted during WRITE: next cycle we_n=1, ce_n=1, data_oe=0, state IDLE; a subsequent read completes normally.
